// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver into the command parser.
// The master side is the receiver; the slave side is the parser.
interface uart_cmd_parser_if;
   logic       rx_done_tick;
   logic [7:0] rx_data;

   modport master (output rx_done_tick, output rx_data);
   modport slave  (input  rx_done_tick, input  rx_data);
endinterface

// File: rtl/uart_cmd_parser.sv
// Framed command parser: SYNC, CMD, big-endian payload, XOR checksum.
// Validated values are committed to the DDS control registers with a one-cycle update strobe.
module uart_cmd_parser #(
   parameter int         FTW_W        = 32,
   parameter int         TIMEOUT_CLKS = 1000000,
   parameter logic [7:0] SYNC_BYTE    = 8'hAA
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_cmd_parser_if.slave     rx,
   output logic [FTW_W-1:0]     ftw,
   output logic [1:0]           wave_sel,
   output logic [7:0]           amplitude,
   output logic                 ftw_update,
   output logic                 wave_update,
   output logic                 amp_update,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int         NBYTES    = FTW_W / 8;
   localparam logic [2:0] FTW_BYTES = NBYTES[2:0];
   localparam int         TMO_W     = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_PAYLOAD, ST_CHECK} state_t;
   typedef enum logic [1:0] {TGT_FTW, TGT_WAVE, TGT_AMP, TGT_NONE} target_t;

   state_t             state, state_nxt;
   target_t            target, target_nxt;
   logic [2:0]         cnt, cnt_nxt;
   logic [7:0]         chk, chk_nxt;
   logic [FTW_W-1:0]   shadow, shadow_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
   logic               commit_ftw, commit_wave, commit_amp, err;

   function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

   // Frame state register, working registers and committed outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         target      <= TGT_NONE;
         cnt         <= 3'd0;
         chk         <= 8'h00;
         shadow      <= '0;
         tmo_cnt     <= '0;
         ftw         <= '0;
         wave_sel    <= 2'b00;
         amplitude   <= 8'h00;
         ftw_update  <= 1'b0;
         wave_update <= 1'b0;
         amp_update  <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         target      <= target_nxt;
         cnt         <= cnt_nxt;
         chk         <= chk_nxt;
         shadow      <= shadow_nxt;
         tmo_cnt     <= tmo_nxt;
         ftw_update  <= commit_ftw;
         wave_update <= commit_wave;
         amp_update  <= commit_amp;
         frame_err   <= err;
         busy        <= (state_nxt != ST_IDLE);
         if (commit_ftw) begin
            ftw <= shadow;
         end
         if (commit_wave) begin
            wave_sel <= shadow[1:0];
         end
         if (commit_amp) begin
            amplitude <= shadow[7:0];
         end
      end
   end

   // Next-state, byte handling and inter-byte timeout.
   always_comb begin
      state_nxt   = state;
      target_nxt  = target;
      cnt_nxt     = cnt;
      chk_nxt     = chk;
      shadow_nxt  = shadow;
      tmo_nxt     = tmo_cnt;
      commit_ftw  = 1'b0;
      commit_wave = 1'b0;
      commit_amp  = 1'b0;
      err         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rx.rx_done_tick && (rx.rx_data == SYNC_BYTE)) begin
               state_nxt  = ST_CMD;
               shadow_nxt = '0;
               chk_nxt    = 8'h00;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (rx.rx_done_tick) begin
               chk_nxt = rx.rx_data;
               case (rx.rx_data)
                  8'h01: begin
                     target_nxt = TGT_FTW;
                     cnt_nxt    = FTW_BYTES;
                     state_nxt  = ST_PAYLOAD;
                  end
                  8'h02: begin
                     target_nxt = TGT_WAVE;
                     cnt_nxt    = 3'd1;
                     state_nxt  = ST_PAYLOAD;
                  end
                  8'h03: begin
                     target_nxt = TGT_AMP;
                     cnt_nxt    = 3'd1;
                     state_nxt  = ST_PAYLOAD;
                  end
                  default: begin
                     err       = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               endcase
            end else begin
               state_nxt = ST_CMD;
            end
         end
         ST_PAYLOAD: begin
            // SYNC_BYTE is plain data here; no resync inside a frame.
            if (rx.rx_done_tick) begin
               shadow_nxt = (shadow << 4'd8) | FTW_W'(rx.rx_data);
               chk_nxt    = chk_accum(chk, rx.rx_data);
               cnt_nxt    = cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state_nxt = ST_CHECK;
               end else begin
                  state_nxt = ST_PAYLOAD;
               end
            end else begin
               state_nxt = ST_PAYLOAD;
            end
         end
         ST_CHECK: begin
            if (rx.rx_done_tick) begin
               state_nxt = ST_IDLE;
               if (rx.rx_data == chk) begin
                  case (target)
                     TGT_FTW:  commit_ftw  = 1'b1;
                     TGT_WAVE: commit_wave = 1'b1;
                     TGT_AMP:  commit_amp  = 1'b1;
                     default:  err         = 1'b1;
                  endcase
               end else begin
                  err = 1'b1;
               end
            end else begin
               state_nxt = ST_CHECK;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A byte arriving on the expiry cycle wins over the timeout.
      if ((state != ST_IDLE) && !rx.rx_done_tick) begin
         if (tmo_cnt == TMO_MAX) begin
            err       = 1'b1;
            state_nxt = ST_IDLE;
            tmo_nxt   = '0;
         end else begin
            tmo_nxt = tmo_cnt + TMO_ONE;
         end
      end else begin
         tmo_nxt = '0;
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (FTW_W=32, TIMEOUT_CLKS=100).
module tb_uart_cmd_parser;

   logic        clk;
   logic        reset;
   logic [31:0] ftw;
   logic [1:0]  wave_sel;
   logic [7:0]  amplitude;
   logic        ftw_update, wave_update, amp_update, frame_err, busy;

   int tests;
   int fails;
   int n_ftw, n_wave, n_amp, n_err;

   uart_cmd_parser_if rx_if ();

   uart_cmd_parser #(
      .FTW_W        (32),
      .TIMEOUT_CLKS (100),
      .SYNC_BYTE    (8'hAA)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx_if),
      .ftw         (ftw),
      .wave_sel    (wave_sel),
      .amplitude   (amplitude),
      .ftw_update  (ftw_update),
      .wave_update (wave_update),
      .amp_update  (amp_update),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (ftw_update)  n_ftw  <= n_ftw + 1;
      if (wave_update) n_wave <= n_wave + 1;
      if (amp_update)  n_amp  <= n_amp + 1;
      if (frame_err)   n_err  <= n_err + 1;
   end

   task automatic clear_counts();
      @(negedge clk);
      #1;
      n_ftw = 0; n_wave = 0; n_amp = 0; n_err = 0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   // One byte with a one-cycle tick; returns on the negedge after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_if.rx_done_tick = 1'b1;
      rx_if.rx_data      = b;
      @(negedge clk);
      rx_if.rx_done_tick = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tests++; if (ftw !== 32'h0) begin fails++; $display("FAIL reset_ftw: got %h expected %h", ftw, 32'h0); end
      tests++; if (wave_sel !== 2'b00) begin fails++; $display("FAIL reset_wave: got %b expected 00", wave_sel); end
      tests++; if (amplitude !== 8'h00) begin fails++; $display("FAIL reset_amp: got %h expected 00", amplitude); end
      tests++; if ({ftw_update, wave_update, amp_update, frame_err} !== 4'b0000) begin
         fails++; $display("FAIL reset_pulses: got %b expected 0000", {ftw_update, wave_update, amp_update, frame_err}); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_ftw_frame();
      clear_counts();
      send_frame('{8'hAA, 8'h01});
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ftw_busy_mid: got %b expected 1", busy); end
      send_frame('{8'h12, 8'h34, 8'h56, 8'h78, 8'h09});
      tests++; if (ftw !== 32'h12345678) begin fails++; $display("FAIL ftw_value: got %h expected 12345678", ftw); end
      tests++; if (ftw_update !== 1'b1) begin fails++; $display("FAIL ftw_strobe: got %b expected 1", ftw_update); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ftw_busy_end: got %b expected 0", busy); end
      @(negedge clk);
      tests++; if (ftw_update !== 1'b0) begin fails++; $display("FAIL ftw_strobe_width: got %b expected 0", ftw_update); end
      settle();
      tests++; if (n_ftw !== 1 || n_err !== 0) begin
         fails++; $display("FAIL ftw_counts: got ftw=%0d err=%0d expected ftw=1 err=0", n_ftw, n_err); end
   endtask

   task automatic test_wave_amp();
      clear_counts();
      send_frame('{8'hAA, 8'h02, 8'h03, 8'h01});
      tests++; if (wave_sel !== 2'b11 || wave_update !== 1'b1) begin
         fails++; $display("FAIL wave_commit: got %b/%b expected 11/1", wave_sel, wave_update); end
      send_frame('{8'hAA, 8'h03, 8'h80, 8'h83});
      tests++; if (amplitude !== 8'h80 || amp_update !== 1'b1) begin
         fails++; $display("FAIL amp_commit: got %h/%b expected 80/1", amplitude, amp_update); end
      settle();
      tests++; if (ftw !== 32'h12345678) begin fails++; $display("FAIL wa_ftw_kept: got %h expected 12345678", ftw); end
      tests++; if (n_wave !== 1 || n_amp !== 1 || n_ftw !== 0 || n_err !== 0) begin
         fails++; $display("FAIL wa_counts: got w=%0d a=%0d f=%0d e=%0d expected 1 1 0 0", n_wave, n_amp, n_ftw, n_err); end
   endtask

   task automatic test_bad_checksum();
      clear_counts();
      send_frame('{8'hAA, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A});
      tests++; if (frame_err !== 1'b1 || ftw_update !== 1'b0) begin
         fails++; $display("FAIL badchk_err: got err=%b upd=%b expected 1/0", frame_err, ftw_update); end
      tests++; if (ftw !== 32'h12345678) begin fails++; $display("FAIL badchk_ftw_kept: got %h expected 12345678", ftw); end
      send_frame('{8'hAA, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23});
      tests++; if (ftw !== 32'hDEADBEEF || ftw_update !== 1'b1) begin
         fails++; $display("FAIL badchk_recover: got %h/%b expected deadbeef/1", ftw, ftw_update); end
      settle();
      tests++; if (n_err !== 1 || n_ftw !== 1) begin
         fails++; $display("FAIL badchk_counts: got err=%0d ftw=%0d expected 1 1", n_err, n_ftw); end
   endtask

   task automatic test_unknown_cmd();
      clear_counts();
      send_byte(8'h55);
      send_byte(8'h13);
      tests++; if (frame_err !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL garbage_quiet: got err=%b busy=%b expected 0/0", frame_err, busy); end
      send_frame('{8'hAA, 8'h07});
      tests++; if (frame_err !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL unknown_cmd: got err=%b busy=%b expected 1/0", frame_err, busy); end
      send_frame('{8'hAA, 8'h01, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h01});
      tests++; if (ftw !== 32'hAAAAAAAA || ftw_update !== 1'b1) begin
         fails++; $display("FAIL sync_in_payload: got %h/%b expected aaaaaaaa/1", ftw, ftw_update); end
      settle();
      tests++; if (n_err !== 1) begin fails++; $display("FAIL unknown_err_count: got %0d expected 1", n_err); end
   endtask

   task automatic test_timeout();
      int early_err;
      clear_counts();
      early_err = 0;
      send_frame('{8'hAA, 8'h01, 8'h12});
      repeat (99) begin
         @(negedge clk);
         if (frame_err !== 1'b0 || busy !== 1'b1) early_err++;
      end
      tests++; if (early_err !== 0) begin fails++; $display("FAIL timeout_early: got %0d bad cycles expected 0", early_err); end
      @(negedge clk);
      tests++; if (frame_err !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL timeout_fire: got err=%b busy=%b expected 1/0", frame_err, busy); end
      @(negedge clk);
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL timeout_width: got %b expected 0", frame_err); end

      // Byte lands on the expiry cycle: it must be taken, no error.
      send_frame('{8'hAA, 8'h01, 8'h12});
      repeat (99) @(negedge clk);
      rx_if.rx_done_tick = 1'b1;
      rx_if.rx_data      = 8'h34;
      @(negedge clk);
      rx_if.rx_done_tick = 1'b0;
      tests++; if (frame_err !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL timeout_byte_wins: got err=%b busy=%b expected 0/1", frame_err, busy); end
      send_frame('{8'h56, 8'h77, 8'h06});
      tests++; if (ftw !== 32'h12345677 || ftw_update !== 1'b1) begin
         fails++; $display("FAIL timeout_continue: got %h/%b expected 12345677/1", ftw, ftw_update); end
      settle();
      tests++; if (n_err !== 1) begin fails++; $display("FAIL timeout_err_count: got %0d expected 1", n_err); end
   endtask

   task automatic test_reset_mid_frame();
      clear_counts();
      send_frame('{8'hAA, 8'h01, 8'h12, 8'h34});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++; if (ftw !== 32'h0 || wave_sel !== 2'b00 || amplitude !== 8'h00 || busy !== 1'b0) begin
         fails++; $display("FAIL midreset_outputs: got %h %b %h busy=%b expected 0 0 0 0", ftw, wave_sel, amplitude, busy); end
      send_frame('{8'hAA, 8'h02, 8'h01, 8'h03});
      tests++; if (wave_sel !== 2'b01 || wave_update !== 1'b1) begin
         fails++; $display("FAIL midreset_recover: got %b/%b expected 01/1", wave_sel, wave_update); end
      tests++; if (ftw !== 32'h0) begin fails++; $display("FAIL midreset_ftw: got %h expected 0", ftw); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [8];
      seq = '{8'hAA, 8'h03, 8'h5A, 8'h59, 8'hAA, 8'h02, 8'h02, 8'h00};
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rx_if.rx_done_tick = 1'b1;
         rx_if.rx_data      = seq[i];
         if (i == 4) begin
            tests++; if (amplitude !== 8'h5A || amp_update !== 1'b1) begin
               fails++; $display("FAIL b2b_amp: got %h/%b expected 5a/1", amplitude, amp_update); end
         end
      end
      @(negedge clk);
      rx_if.rx_done_tick = 1'b0;
      tests++; if (wave_sel !== 2'b10 || wave_update !== 1'b1) begin
         fails++; $display("FAIL b2b_wave: got %b/%b expected 10/1", wave_sel, wave_update); end
      settle();
      tests++; if (n_amp !== 1 || n_wave !== 1 || n_err !== 0) begin
         fails++; $display("FAIL b2b_counts: got a=%0d w=%0d e=%0d expected 1 1 0", n_amp, n_wave, n_err); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      n_ftw = 0; n_wave = 0; n_amp = 0; n_err = 0;
      reset = 1'b1;
      rx_if.rx_done_tick = 1'b0;
      rx_if.rx_data      = 8'h00;
      test_reset();
      test_ftw_frame();
      test_wave_amp();
      test_bad_checksum();
      test_unknown_cmd();
      test_timeout();
      test_reset_mid_frame();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream: rx_done_tick strobe plus 8-bit data.
- Assembles framed commands, validates each frame with an XOR checksum, and commits validated values to the DDS control registers (frequency tuning word, waveform select, amplitude).
- Each committed register change is accompanied by a one-cycle update strobe for the DDS core.

Parameters:
- FTW_W, 32: width of the frequency tuning word; multiple of 8, range 8..32.
- TIMEOUT_CLKS, 1000000: maximum idle clock cycles between bytes inside a frame before the frame is aborted.
- SYNC_BYTE, 8'hAA: frame start marker.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_done_tick  input  1  one-cycle strobe; rx_data is valid while it is high.
- rx_data  input  8  received byte.
- ftw  output  FTW_W  committed frequency tuning word.
- wave_sel  output  2  committed waveform select.
- amplitude  output  8  committed amplitude.
- ftw_update  output  1  one-cycle pulse when ftw is committed.
- wave_update  output  1  one-cycle pulse when wave_sel is committed.
- amp_update  output  1  one-cycle pulse when amplitude is committed.
- frame_err  output  1  one-cycle pulse on any rejected frame.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset:
  - FSM goes to IDLE; shadow, counters and checksum are cleared.
  - Outputs: ftw=0, wave_sel=0, amplitude=0, all strobes=0, frame_err=0, busy=0.
  - Reset asserted mid-frame discards the partial frame; committed outputs return to 0.
- Byte processing: the FSM advances only on cycles where rx_done_tick=1. Back-to-back ticks on consecutive cycles are each processed.
- Frame format: SYNC_BYTE, CMD, payload (big-endian, MS byte first), CHK. CHK = XOR of CMD and all payload bytes.
- Commands and payload length:
  - 8'h01: ftw, FTW_W/8 bytes.
  - 8'h02: wave_sel, 1 byte; bits [1:0] are used.
  - 8'h03: amplitude, 1 byte.
- FSM states:
  - IDLE: a byte equal to SYNC_BYTE moves to CMD and clears the timeout counter. Any other byte is dropped silently, with no error.
  - CMD: a valid command latches the command, loads the byte count = payload length, sets checksum = CMD, and moves to PAYLOAD. An unknown command pulses frame_err and returns to IDLE.
  - PAYLOAD: each byte is shifted into a FTW_W-bit shadow register (shadow = {shadow, byte}) and XORed into the checksum; the counter decrements. When the last payload byte is taken, move to CHECK. A byte equal to SYNC_BYTE is treated as ordinary data here, not as a resync.
  - CHECK: byte == checksum commits the shadow to the target register, pulses that register's strobe, and returns to IDLE. Byte != checksum pulses frame_err, leaves outputs unchanged, and returns to IDLE.
- Latency: the committed value and its strobe both appear in the cycle after the cycle where the checksum byte's rx_done_tick is sampled. Strobe and data change together.
- Byte width of 1-byte commands: only the low 8 bits of the shadow are used (wave_sel = shadow[1:0], amplitude = shadow[7:0]).
- Timeout:
  - The counter runs in CMD, PAYLOAD and CHECK, and clears on every accepted byte.
  - When it reaches TIMEOUT_CLKS-1 with no tick: frame_err pulses and the FSM returns to IDLE.
  - If a tick arrives in the same cycle the timeout is reached, the byte wins: it is processed and no error is raised.
  - The counter must be wide enough for TIMEOUT_CLKS without wrap.
- Pulse exclusivity: frame_err and the update strobes are never asserted in the same cycle; at most one update strobe is asserted per cycle.

Test Plan:
- Frequency frame: bytes AA 01 12 34 56 78 09 (FTW_W=32) -> ftw=32'h12345678, ftw_update high for exactly 1 cycle, frame_err=0, busy=0 afterwards.
- Waveform and amplitude frames: AA 02 03 01 -> wave_sel=2'b11 with wave_update pulse; then AA 03 80 83 -> amplitude=8'h80 with amp_update pulse; ftw unchanged.
- Bad checksum: AA 01 12 34 56 78 0A -> frame_err 1-cycle pulse, ftw keeps its prior value, no ftw_update; a following valid frame is accepted.
- Unknown command and garbage: 55 13 AA 07 -> no error on 55 or 13, frame_err pulse on 07, FSM returns to IDLE; SYNC inside payload (AA 01 AA AA AA AA 01, checksum = 01^AA^AA^AA^AA) -> ftw=32'hAAAAAAAA committed.
- Timeout (TIMEOUT_CLKS=100): AA 01 12 then 100 idle cycles -> frame_err pulse, busy drops; a tick arriving exactly at cycle 99 -> no error, frame continues.
- Reset mid-frame: AA 01 12 34, assert reset 1 cycle -> outputs 0, busy=0; then AA 02 01 03 -> wave_sel=2'b01.
